esm_instr_buffer: RTL and testbench

Instruction buffer feeding the ESM core. It accepts instructions from fetch under a valid/ready handshake and allocates each one to the lowest-numbered free slot of a `bs`-entry window. It presents the instruction, control bits, slot index and valid-entry vector to the dependency-analysis stage. Slots are released by a per-slot issue mask returned from the issue stage.

---
 rtl/esm_pkg.sv | 24 ++
 rtl/esm_free_slot_enc.sv | 25 ++
 rtl/esm_instr_buffer.sv | 108 ++++++++++
 tb/tb_esm_instr_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM instruction buffer.
package esm_pkg;

    localparam int INSTR_W_DEFAULT = 32;
    localparam int BS_DEFAULT      = 16;
    // Widest slot vector popcount() is able to accept.
    localparam int POPCNT_MAX      = 256;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ibuf_state_e;

    function automatic int unsigned popcount(input logic [POPCNT_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCNT_MAX; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/esm_free_slot_enc.sv
// Lowest-zero priority encoder: the first free slot in an occupancy vector.
module esm_free_slot_enc
    import esm_pkg::*;
#(
    parameter  int bs    = BS_DEFAULT,
    localparam int IDX_W = $clog2(bs)
) (
    input  logic [0:bs-1]    occupied,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    // Walk from the top so the lowest free index is the one left standing.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/esm_instr_buffer.sv
// Slot-allocating instruction buffer between fetch and dependency analysis.
// Optional stall statistics counter: define ESM_IBUF_STATS_EN.
module esm_instr_buffer
    import esm_pkg::*;
#(
    parameter  int Instruction_word_size = INSTR_W_DEFAULT,
    parameter  int bs                    = BS_DEFAULT,
    localparam int IDX_W                 = $clog2(bs),
    localparam int CNT_W                 = IDX_W + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Instruction_word_size-1:0] in_instr,
    input  logic                             in_regwrite,
    input  logic                             in_alusrc,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             RegWrite_out,
    output logic                             ALUSrc_out,
    output logic                             wr_strobe,
    output logic [IDX_W-1:0]                 buffer_index,
    output logic [0:bs-1]                    valid_entries,
    input  logic [0:bs-1]                    retire_mask,
    input  logic                             drain,
    output logic                             drain_done,
    output logic [CNT_W-1:0]                 count,
    output logic                             full,
    output logic                             empty,
    output logic [31:0]                      stall_cycles
);

    ibuf_state_e      state;
    logic [IDX_W-1:0] free_idx;
    logic             any_free;
    logic             accept;
    logic [0:bs-1]    alloc_onehot;

    esm_free_slot_enc #(.bs(bs)) u_free_enc (
        .occupied (valid_entries),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign count    = CNT_W'(popcount(POPCNT_MAX'(valid_entries)));
    assign full     = (count == CNT_W'(bs));
    assign empty    = (count == '0);
    assign in_ready = (state == RUN) && !full;
    assign accept   = in_valid && in_ready && any_free;

    always_comb begin
        alloc_onehot           = '0;
        alloc_onehot[free_idx] = accept;
    end

    // The allocated slot was free before the edge, so retire and allocate never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_entries <= '0;
            wr_strobe     <= 1'b0;
            Instr_out     <= '0;
            RegWrite_out  <= 1'b0;
            ALUSrc_out    <= 1'b0;
            buffer_index  <= '0;
        end else begin
            valid_entries <= (valid_entries & ~retire_mask) | alloc_onehot;
            wr_strobe     <= accept;
            if (accept) begin
                Instr_out    <= in_instr;
                RegWrite_out <= in_regwrite;
                ALUSrc_out   <= in_alusrc;
                buffer_index <= free_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            drain_done <= (state == DRAIN) && empty;
            case (state)
                RUN:     if (drain) state <= DRAIN;
                DRAIN:   if (empty) state <= DONE;
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef ESM_IBUF_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_esm_instr_buffer.sv
// Directed plus randomized bench for esm_instr_buffer against a slot-level reference model.
module tb_esm_instr_buffer;

    localparam int W  = 32;
    localparam int BS = 16;
    localparam int IW = 4;
    localparam int CW = 5;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_regwrite, in_alusrc;
    logic [W-1:0]  in_instr, Instr_out;
    logic          RegWrite_out, ALUSrc_out, wr_strobe;
    logic [IW-1:0] buffer_index;
    logic [0:BS-1] valid_entries, retire_mask;
    logic          drain, drain_done, full, empty;
    logic [CW-1:0] count;
    logic [31:0]   stall_cycles;

    always #5 clk = ~clk;

    esm_instr_buffer #(.Instruction_word_size(W), .bs(BS)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_regwrite   (in_regwrite),
        .in_alusrc     (in_alusrc),
        .Instr_out     (Instr_out),
        .RegWrite_out  (RegWrite_out),
        .ALUSrc_out    (ALUSrc_out),
        .wr_strobe     (wr_strobe),
        .buffer_index  (buffer_index),
        .valid_entries (valid_entries),
        .retire_mask   (retire_mask),
        .drain         (drain),
        .drain_done    (drain_done),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .stall_cycles  (stall_cycles)
    );

    // Reference model: per-slot occupancy plus the last-accepted record.
    bit           m_occ[BS];
    int           m_mode;
    logic [W-1:0] m_instr;
    bit           m_rw, m_as, m_strobe, m_done;
    int           m_idx;
    longint       m_stall;

    int total = 0;
    int bad   = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < BS; i++) n += m_occ[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit m_ready();
        return (m_mode == M_RUN) && (m_count() != BS);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) m_occ[i] = 1'b0;
        m_mode = M_RUN; m_instr = '0; m_rw = 0; m_as = 0;
        m_strobe = 0; m_done = 0; m_idx = 0; m_stall = 0;
    endtask

    task automatic model_step();
        bit rdy, acc, was_empty;
        int slot;
        rdy = m_ready();
        acc = in_valid && rdy;
        was_empty = (m_count() == 0);
        slot = -1;
        for (int i = 0; i < BS; i++) if (!m_occ[i] && slot < 0) slot = i;
        if (in_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
        for (int i = 0; i < BS; i++) if (retire_mask[i]) m_occ[i] = 1'b0;
        if (acc) begin
            m_occ[slot] = 1'b1;
            m_instr = in_instr; m_rw = in_regwrite; m_as = in_alusrc; m_idx = slot;
        end
        m_strobe = acc;
        case (m_mode)
            M_RUN:   if (drain) m_mode = M_DRAIN;
            M_DRAIN: if (was_empty) m_mode = M_DONE;
            default: m_mode = M_RUN;
        endcase
        m_done = (m_mode == M_DONE);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [0:BS-1] v;
        longint exp_stall;
        for (int i = 0; i < BS; i++) v[i] = m_occ[i];
`ifdef ESM_IBUF_STATS_EN
        exp_stall = m_stall;
`else
        exp_stall = 0;
`endif
        chk("valid_entries", 64'(valid_entries), 64'(v));
        chk("count", 64'(count), 64'(m_count()));
        chk("full", 64'(full), 64'(m_count() == BS));
        chk("empty", 64'(empty), 64'(m_count() == 0));
        chk("in_ready", 64'(in_ready), 64'(m_ready()));
        chk("wr_strobe", 64'(wr_strobe), 64'(m_strobe));
        chk("buffer_index", 64'(buffer_index), 64'(m_idx));
        chk("Instr_out", 64'(Instr_out), 64'(m_instr));
        chk("RegWrite_out", 64'(RegWrite_out), 64'(m_rw));
        chk("ALUSrc_out", 64'(ALUSrc_out), 64'(m_as));
        chk("drain_done", 64'(drain_done), 64'(m_done));
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Asynchronous reset with no clock edge while it is held.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_valid", 64'(valid_entries), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
    endtask

    initial begin
        int pulses, strobes;
        logic [W-1:0] a;
        rst = 1'b0; in_valid = 0; in_instr = '0; in_regwrite = 0; in_alusrc = 0;
        retire_mask = '0; drain = 0;
        model_reset();

        // Three back-to-back accepts land in slots 0, 1, 2.
        do_reset();
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            a = 32'hA + 32'(k);
            in_instr = a; in_regwrite = k[0]; in_alusrc = ~k[0];
            cycle();
            chk("t1_index", 64'(buffer_index), 64'(k));
            chk("t1_instr", 64'(Instr_out), 64'(a));
        end
        in_valid = 0;
        cycle();
        chk("t1_vector", 64'(valid_entries), 64'hE000);
        chk("t1_count", 64'(count), 64'd3);

        // Fill, stall for 10 cycles, then a retire of slot 5 reopens it.
        do_reset();
        in_valid = 1;
        for (int k = 0; k < BS; k++) begin
            in_instr = $urandom; cycle();
        end
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_not_ready", 64'(in_ready), 64'd0);
        repeat (10) cycle();
`ifdef ESM_IBUF_STATS_EN
        chk("t2_stall", 64'(stall_cycles), 64'd10);
`else
        chk("t2_stall", 64'(stall_cycles), 64'd0);
`endif
        retire_mask[5] = 1'b1;
        cycle();
        retire_mask = '0;
        chk("t2_ready_after_retire", 64'(in_ready), 64'd1);
        in_instr = 32'h5555_0005;
        cycle();
        chk("t2_reuse_slot", 64'(buffer_index), 64'd5);
        in_valid = 0;

        // Slot freed this edge is not reused; the accept takes slot 1.
        do_reset();
        in_valid = 1; in_instr = 32'h100; cycle();
        retire_mask[0] = 1'b1; in_instr = 32'h101; cycle();
        retire_mask = '0; in_valid = 0;
        chk("t3_index", 64'(buffer_index), 64'd1);
        chk("t3_vector", 64'(valid_entries), 64'h4000);

        // Drain with fetch still offering: one drain_done, then accepts resume.
        do_reset();
        in_valid = 1;
        repeat (4) begin in_instr = $urandom; cycle(); end
        drain = 1; cycle(); drain = 0;
        chk("t4_ready_low", 64'(in_ready), 64'd0);
        retire_mask = '1; cycle(); retire_mask = '0;
        pulses = 0; strobes = 0;
        for (int k = 0; k < 8; k++) begin
            in_instr = $urandom; cycle();
            pulses  += drain_done ? 1 : 0;
            strobes += (pulses == 1 && wr_strobe) ? 1 : 0;
        end
        chk("t4_done_pulses", 64'(pulses), 64'd1);
        chk("t4_resumed", 64'(strobes > 0), 64'd1);
        in_valid = 0;

        // Drain of an already-empty buffer: drain_done two cycles later.
        do_reset();
        drain = 1; cycle(); drain = 0;
        cycle();
        chk("t4b_done", 64'(drain_done), 64'd1);
        cycle();
        chk("t4b_done_once", 64'(drain_done), 64'd0);

        // Retire on an empty slot is ignored; mid-stream reset clears everything.
        do_reset();
        in_valid = 1; cycle(); cycle(); in_valid = 0;
        retire_mask[9] = 1'b1; cycle(); retire_mask = '0;
        chk("t5_count", 64'(count), 64'd2);
        in_valid = 1;
        do_reset();
        chk("t5_count_rst", 64'(count), 64'd0);
        in_valid = 0;

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_instr    = $urandom;
            in_regwrite = $urandom_range(0, 1) != 0;
            in_alusrc   = $urandom_range(0, 1) != 0;
            retire_mask = BS'($urandom & $urandom & $urandom);
            drain       = ($urandom_range(0, 40) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
